rom_loader: RTL and testbench

- Copy engine between the byte-wide boot/data ROM and the 32-bit data memory.
- On a start pulse it streams N bytes from the ROM, packs them little-endian into 32-bit words and writes them to data memory.
- It holds the processor in stall (busy) until the copy completes.
- Sits between the ROM output port and the dmem write port; dmem write signals are muxed with the CPU's while busy=1.

---
 rtl/rom_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_rom_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
//
// Copy engine from the byte-wide boot/data ROM into the 32-bit data memory.
// On an accepted start pulse it streams byte_count bytes starting at src_addr.
// It packs them little-endian (first byte in bits [7:0]) into 32-bit words and
// writes each word to data memory. The first word goes to dst_addr & ~3, and
// each following word goes 4 bytes higher. busy stalls the CPU for the whole
// copy, and done pulses once at the end.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   start       one-cycle copy request, sampled only while idle
//   src_addr    first ROM byte address
//   dst_addr    dmem byte address of the first word (bits [1:0] ignored)
//   byte_count  number of bytes to copy (0 = complete immediately)
//   rom_addr    ROM read address (one new address per cycle while issuing)
//   rom_data    ROM read data, valid RD_LAT cycles after rom_addr changes
//   mem_we      one-cycle dmem write strobe
//   mem_addr    dmem byte address of the written word (4-aligned)
//   mem_wdata   packed word (unfilled upper lanes of a final word are 0)
//   busy        copy in progress (CPU stall, dmem port muxed to this block)
//   done        one-cycle completion pulse
//   checksum    8-bit modular sum of copied bytes
//               (present only when ROM_LOADER_CHECKSUM_EN is defined)
//
// Parameters:
//   ROM_AW  ROM address width
//   RD_LAT  ROM read latency in cycles, legal range 1..4
//   LEN_W   width of byte_count
//
// Optional feature macro: ROM_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module rom_loader #(
  parameter int ROM_AW = 16,
  parameter int RD_LAT = 2,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROM_AW-1:0] src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [LEN_W-1:0]  byte_count,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
`ifdef ROM_LOADER_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,   // waiting for start
    ISSUE,  // one ROM address per cycle
    DRAIN,  // all addresses issued, waiting for the last write
    FIN     // last write issued; done pulses on the way back to IDLE
  } state_t;

  state_t state, state_nxt;

  // Latched copy parameters and progress counters.
  logic [LEN_W-1:0]  len_q;     // total byte count of the current copy
  logic [LEN_W-1:0]  iss_left;  // addresses still to be issued
  logic [LEN_W-1:0]  rcv_cnt;   // bytes received so far (j)
  logic [ROM_AW-1:0] nxt_addr;  // next ROM address to issue
  logic [31:0]       wr_addr;   // dmem address of the word being packed
  logic [31:0]       pack;      // partially filled word

  // addr_vld marks that rom_addr holds a freshly issued address. vld_pipe
  // delays that mark by RD_LAT cycles so its tap lines up with rom_data.
  logic              addr_vld;
  logic [RD_LAT-1:0] vld_pipe;
  logic              last_wr;   // the strobe now on mem_we is the final one

  // Decodes from the FSM output process.
  logic accept;    // start accepted with a non-zero length
  logic zero_req;  // start accepted with zero length: done only
  logic issue_en;  // issue the next ROM address this cycle

  // Capture-side decodes.
  logic        cap;
  logic [1:0]  lane;
  logic        last_byte;
  logic        wr_now;
  logic [31:0] cap_word;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: default assignment first so no path leaves state_nxt unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      // iss_left is N-1 on entry because the first address goes out on the
      // accepting edge, so a value <= 1 means this is the last issue cycle.
      ISSUE: if (iss_left <= LEN_W'(1)) state_nxt = DRAIN;
      DRAIN: if (last_wr) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = (state != IDLE);
    accept   = (state == IDLE) && start && (byte_count != '0);
    zero_req = (state == IDLE) && start && (byte_count == '0);
    issue_en = (state == ISSUE) && (iss_left != '0);
  end

  // A token leaving the delay line means rom_data now holds byte rcv_cnt.
  assign cap       = vld_pipe[RD_LAT-1];
  assign lane      = rcv_cnt[1:0];
  assign last_byte = (rcv_cnt == len_q - LEN_W'(1));
  assign wr_now    = cap && ((lane == 2'd3) || last_byte);
  assign cap_word  = pack | (32'(rom_data) << {lane, 3'b000});

  // ---------------------------------------------------------------------------
  // Datapath: address issue, byte capture/pack, write strobe, done pulse
  // ---------------------------------------------------------------------------
  // NOTE: every datapath flop is in the async reset. A reset mid-copy must
  // drop the partial word and the in-flight tokens, not just the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      iss_left  <= '0;
      rcv_cnt   <= '0;
      nxt_addr  <= '0;
      wr_addr   <= '0;
      pack      <= '0;
      addr_vld  <= 1'b0;
      vld_pipe  <= '0;
      last_wr   <= 1'b0;
      rom_addr  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
    end else begin
      addr_vld    <= 1'b0;
      mem_we      <= 1'b0;
      last_wr     <= 1'b0;
      vld_pipe[0] <= addr_vld;
      for (int k = 1; k < RD_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];

      // done covers both the zero-length request and normal completion.
      done <= zero_req || (state == FIN);

      if (accept) begin
        // The first address is issued directly from the request. This keeps
        // issue gapless and lands the first write at RD_LAT+4.
        len_q    <= byte_count;
        iss_left <= byte_count - LEN_W'(1);
        rcv_cnt  <= '0;
        rom_addr <= src_addr;
        nxt_addr <= src_addr + ROM_AW'(1);
        addr_vld <= 1'b1;
        wr_addr  <= {dst_addr[31:2], 2'b00};
        pack     <= '0;
      end else if (issue_en) begin
        rom_addr <= nxt_addr;
        nxt_addr <= nxt_addr + ROM_AW'(1);
        iss_left <= iss_left - LEN_W'(1);
        addr_vld <= 1'b1;
      end

      if (cap) begin
        rcv_cnt <= rcv_cnt + LEN_W'(1);
        if (wr_now) begin
          // The word is written straight from the capture so that no byte
          // waits an extra cycle. The pack register restarts empty.
          mem_we    <= 1'b1;
          mem_addr  <= wr_addr;
          mem_wdata <= cap_word;
          wr_addr   <= wr_addr + 32'd4;
          pack      <= '0;
          last_wr   <= last_byte;
        end else begin
          pack <= cap_word;
        end
      end
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Running 8-bit sum of every captured byte. It restarts on an accepted
  // start and holds after done until the next accepted start.
  // ---------------------------------------------------------------------------
  logic [7:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       csum_q <= '0;
    else if (accept) csum_q <= '0;
    else if (cap)    csum_q <= csum_q + rom_data;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_rom_loader
//
// Self-checking bench for rom_loader. A behavioural ROM with RD_LAT cycles of
// read latency feeds the DUT. Each copy is compared against a reference
// computed directly from the copy rules. The bench derives the expected
// words, addresses and write cycles from the byte stream, derives the done
// cycle as N+RD_LAT+2, and derives the rom_addr sequence as src+i. The bench
// runs a table of directed copies, a mid-copy reset sequence, and a batch
// of randomized copies.
// -----------------------------------------------------------------------------
module tb_rom_loader;

  localparam int ROM_AW = 16;
  localparam int RD_LAT = 2;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ROM_AW-1:0] src_addr;
  logic [31:0]       dst_addr;
  logic [LEN_W-1:0]  byte_count;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rom_loader #(.ROM_AW(ROM_AW), .RD_LAT(RD_LAT), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .byte_count (byte_count),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
`ifdef ROM_LOADER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  // Registered-address ROM: rom_data matches rom_addr RD_LAT cycles after
  // the address changes.
  logic [7:0]        rom_mem [65536];
  logic [ROM_AW-1:0] ap [RD_LAT];

  always @(posedge clk) begin
    ap[0] <= rom_addr;
    for (int k = 1; k < RD_LAT; k++) ap[k] <= ap[k-1];
  end
  assign rom_data = rom_mem[ap[RD_LAT-1]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one copy and compares it against the reference.
  // second_at >= 0 pulses start again at that cycle, which the DUT should
  // ignore because it is busy.
  task automatic run_copy(input logic [15:0] src, input logic [31:0] dst,
                          input logic [15:0] n, input int second_at,
                          output int wr_cnt, output logic [31:0] first_addr,
                          output logic [31:0] first_data, output int done_cyc,
                          output logic [7:0] csum_at_done);
    logic [31:0] e_addr[$], e_data[$];
    int          e_cyc[$];
    logic [31:0] g_addr[$], g_data[$];
    int          g_cyc[$];
    logic [31:0] word, hold_addr, hold_data;
    logic [15:0] idle_addr;
    logic [7:0]  esum;
    logic        exp_busy;
    int nw, lb, idx, exp_done, last_cyc, done_cnt, busy_err, rom_err;

    // Reference: bytes src+i (mod 2^16), grouped four at a time, little-endian.
    esum = 8'h00;
    nw   = (int'(n) + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      word = 32'h0;
      for (int b = 0; b < 4; b++) begin
        idx = 4 * w + b;
        if (idx < int'(n)) begin
          word = word | (32'(rom_mem[16'(src + 16'(idx))]) << (8 * b));
          esum = esum + rom_mem[16'(src + 16'(idx))];
        end
      end
      e_addr.push_back({dst[31:2], 2'b00} + 32'(4 * w));
      e_data.push_back(word);
      // Byte i arrives RD_LAT cycles after issue at cycle i; a word is
      // written the cycle after its last byte is captured.
      lb = (4 * w + 3 < int'(n)) ? 4 * w + 3 : int'(n) - 1;
      e_cyc.push_back(lb + RD_LAT + 1);
    end
    exp_done = (n == 16'd0) ? 0 : int'(n) + RD_LAT + 2;
    last_cyc = exp_done + 4;

    done_cnt = 0; done_cyc = -1; busy_err = 0; rom_err = 0;
    hold_addr = 32'h0; hold_data = 32'h0; csum_at_done = 8'h00;

    @(negedge clk);
    idle_addr  = rom_addr;
    start      = 1'b1;
    src_addr   = src;
    dst_addr   = dst;
    byte_count = n;
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc <= last_cyc; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      if (mem_we === 1'b1) begin
        g_addr.push_back(mem_addr);
        g_data.push_back(mem_wdata);
        g_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc  = cyc;
          hold_addr = mem_addr;
          hold_data = mem_wdata;
`ifdef ROM_LOADER_CHECKSUM_EN
          csum_at_done = checksum;
`endif
        end
      end
      exp_busy = (n != 16'd0) && (cyc < exp_done);
      if (busy !== exp_busy) busy_err++;
      if (n == 16'd0) begin
        if (rom_addr !== idle_addr) rom_err++;
      end else if (cyc < int'(n)) begin
        if (rom_addr !== 16'(src + 16'(cyc))) rom_err++;
      end
      // Scramble the request inputs after the start edge. The DUT must
      // ignore them, including any start pulse issued while busy.
      @(negedge clk);
      start      = (cyc + 1 == second_at);
      src_addr   = 16'($urandom);
      dst_addr   = $urandom;
      byte_count = 16'($urandom);
    end
    start = 1'b0;

    check("wr_count", 64'(g_addr.size()), 64'(e_addr.size()));
    for (int w = 0; w < e_addr.size() && w < g_addr.size(); w++) begin
      check($sformatf("wr%0d_addr", w), 64'(g_addr[w]), 64'(e_addr[w]));
      check($sformatf("wr%0d_data", w), 64'(g_data[w]), 64'(e_data[w]));
      check($sformatf("wr%0d_cycle", w), 64'(g_cyc[w]), 64'(e_cyc[w]));
    end
    check("done_count", 64'(done_cnt), 64'd1);
    check("done_cycle", 64'(done_cyc), 64'(exp_done));
    check("busy_profile_errors", 64'(busy_err), 64'd0);
    check("rom_addr_seq_errors", 64'(rom_err), 64'd0);
    if (n != 16'd0) begin
      check("hold_mem_addr", 64'(hold_addr), 64'(e_addr[e_addr.size()-1]));
      check("hold_mem_wdata", 64'(hold_data), 64'(e_data[e_data.size()-1]));
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    check("checksum_model", 64'(csum_at_done), 64'(esum));
`endif

    wr_cnt     = g_addr.size();
    first_addr = (g_addr.size() > 0) ? g_addr[0] : 32'h0;
    first_data = (g_data.size() > 0) ? g_data[0] : 32'h0;
  endtask

  typedef struct {
    string       name;
    logic [15:0] src;
    logic [31:0] dst;
    logic [15:0] n;
    int          second_at;
    int          exp_wr;
    logic [31:0] exp_addr0;
    logic [31:0] exp_data0;
    int          exp_done;
    logic [7:0]  exp_csum;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          got_wr, got_done;
    logic [31:0] got_addr0, got_data0;
    logic [7:0]  got_csum;
    int          mw, md, mb;
    logic [15:0] rn;
    int          sa;

    for (int a = 0; a < 65536; a++) rom_mem[a] = 8'($urandom);
    for (int a = 0; a < 6; a++) rom_mem[a] = 8'(a + 1);
    rom_mem[16'h0010] = 8'h11; rom_mem[16'h0011] = 8'h22;
    rom_mem[16'h0012] = 8'h33; rom_mem[16'h0013] = 8'h44;
    rom_mem[16'hFFFE] = 8'hAA; rom_mem[16'hFFFF] = 8'hBB;
    rom_mem[16'h0020] = 8'hFF; rom_mem[16'h0021] = 8'h02;
    rom_mem[16'h0022] = 8'h03;

    //            name       src       dst            n   2nd  wr addr0          data0          done csum
    vecs[0] = '{"single",   16'h0010, 32'h0000_0040, 16'd4, -1, 1, 32'h0000_0040, 32'h4433_2211, 8, 8'hAA};
    vecs[1] = '{"partial",  16'h0000, 32'h0000_0103, 16'd6, -1, 2, 32'h0000_0100, 32'h0403_0201, 10, 8'h15};
    vecs[2] = '{"zero_len", 16'h0010, 32'h0000_0080, 16'd0, -1, 0, 32'h0000_0000, 32'h0000_0000, 0, 8'h00};
    vecs[3] = '{"wrap",     16'hFFFE, 32'h0000_0200, 16'd4, 2,  1, 32'h0000_0200, 32'h0201_BBAA, 8, 8'h68};
    vecs[4] = '{"one_byte", 16'h0011, 32'h0000_0007, 16'd1, -1, 1, 32'h0000_0004, 32'h0000_0022, 5, 8'h22};
    vecs[5] = '{"csum",     16'h0020, 32'h0000_0300, 16'd3, -1, 1, 32'h0000_0300, 32'h0003_02FF, 7, 8'h04};

    reset = 1'b1; start = 1'b0;
    src_addr = '0; dst_addr = '0; byte_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rom_addr",  64'(rom_addr),  64'd0);
    check("reset_mem_we",    64'(mem_we),    64'd0);
    check("reset_mem_addr",  64'(mem_addr),  64'd0);
    check("reset_mem_wdata", 64'(mem_wdata), 64'd0);
    check("reset_busy",      64'(busy),      64'd0);
    check("reset_done",      64'(done),      64'd0);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("reset_checksum",  64'(checksum),  64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_copy(vecs[i].src, vecs[i].dst, vecs[i].n, vecs[i].second_at,
               got_wr, got_addr0, got_data0, got_done, got_csum);
      check($sformatf("%s_wr", vecs[i].name),    64'(got_wr),    64'(vecs[i].exp_wr));
      check($sformatf("%s_addr0", vecs[i].name), 64'(got_addr0), 64'(vecs[i].exp_addr0));
      check($sformatf("%s_data0", vecs[i].name), 64'(got_data0), 64'(vecs[i].exp_data0));
      check($sformatf("%s_done", vecs[i].name),  64'(got_done),  64'(vecs[i].exp_done));
`ifdef ROM_LOADER_CHECKSUM_EN
      check($sformatf("%s_csum", vecs[i].name),  64'(got_csum),  64'(vecs[i].exp_csum));
`endif
      repeat (2) @(negedge clk);
    end

    // Reset during the second byte of an 8-byte copy.
    @(negedge clk);
    start = 1'b1; src_addr = 16'h0000; dst_addr = 32'h0000_0500; byte_count = 16'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_rom_addr",  64'(rom_addr),  64'd0);
    check("midrst_mem_we",    64'(mem_we),    64'd0);
    check("midrst_mem_addr",  64'(mem_addr),  64'd0);
    check("midrst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("midrst_busy",      64'(busy),      64'd0);
    check("midrst_done",      64'(done),      64'd0);
    @(negedge clk);
    reset = 1'b0;
    mw = 0; md = 0; mb = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (mem_we !== 1'b0) mw++;
      if (done !== 1'b0) md++;
      if (busy !== 1'b0) mb++;
    end
    check("postrst_mem_we_count", 64'(mw), 64'd0);
    check("postrst_done_count",   64'(md), 64'd0);
    check("postrst_busy_count",   64'(mb), 64'd0);

    // Randomized copies; the first one also serves as the fresh copy after
    // the mid-copy reset.
    for (int r = 0; r < 24; r++) begin
      rn = 16'($urandom_range(0, 40));
      sa = (rn > 16'd2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, int'(rn) - 1)) : -1;
      run_copy(16'($urandom), $urandom, rn, sa,
               got_wr, got_addr0, got_data0, got_done, got_csum);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
